// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - immediate extension (sign/zero/upper/branch) through an elastic valid/ready pipeline
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;

  assign sext = {{PAD_W{in_data[IN_W-1]}}, in_data};

  always_comb begin
    ext = sext;
    unique case (in_mode)
      2'b00: ext = sext;
      2'b01: ext = {{PAD_W{1'b0}}, in_data};
      2'b10: ext = {in_data, {PAD_W{1'b0}}};
      2'b11: ext = sext << 2;
    endcase
  end

  // Each stage owns its valid/data; load ripples back from the output so a
  // full pipe still accepts a new item in the same cycle the tail drains.
  genvar k;
  for (k = 0; k < DEPTH; k++) begin : g_stage
    logic             v;
    logic [OUT_W-1:0] d;
    logic             down_rdy;
    logic             ld;
    logic             src_v;
    logic [OUT_W-1:0] src_d;

    if (k == DEPTH - 1) begin : g_tail
      assign down_rdy = out_ready;
    end else begin : g_mid
      assign down_rdy = g_stage[k+1].ld;
    end

    if (k == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = ext;
    end else begin : g_body
      assign src_v = g_stage[k-1].v;
      assign src_d = g_stage[k-1].d;
    end

    assign ld = !v || down_rdy;

    // Data only moves with a valid item; a bubble leaves the old word in place.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        d <= '0;
      end else if (ld) begin
        v <= src_v;
        if (src_v) begin
          d <= src_d;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].ld;
  assign out_valid = g_stage[DEPTH-1].v;
  assign out_data  = g_stage[DEPTH-1].d;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - directed bench for imm_ext_pipe (default build plus IN_W=8/OUT_W=16 at DEPTH 1 and 4)
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  logic        s_in_valid;
  logic [7:0]  s_in_data;
  logic [1:0]  s_in_mode;
  logic        s_out_ready;
  logic        s1_in_ready, s1_out_valid;
  logic [15:0] s1_out_data;
  logic        s4_in_ready, s4_out_valid;
  logic [15:0] s4_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_ext_pipe u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .DEPTH(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s1_in_ready), .in_data(s_in_data), .in_mode(s_in_mode),
    .out_valid(s1_out_valid), .out_ready(s_out_ready), .out_data(s1_out_data)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .DEPTH(4)) u_s4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s4_in_ready), .in_data(s_in_data), .in_mode(s_in_mode),
    .out_valid(s4_out_valid), .out_ready(s_out_ready), .out_data(s4_out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [15:0] data, input logic [1:0] mode,
                         input logic [31:0] exp);
    int cyc;
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd2);
    check({tag, "_data"}, out_data, exp);
    tick();
  endtask

  initial begin
    int got, first, last, lat1, lat4, cyc, ghosts, held_v;
    logic [31:0] held;
    logic [15:0] d1, d4;
    logic acc, saw_full;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_mode = '0; s_out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_s4_in_ready", 32'(s4_in_ready), 32'd1);
    #11 rst_n = 1'b1;
    tick();

    run_one("m00_neg", 16'hFFF0, 2'b00, 32'hFFFF_FFF0);
    run_one("m00_pos", 16'h000F, 2'b00, 32'h0000_000F);
    run_one("m01", 16'h8001, 2'b01, 32'h0000_8001);
    run_one("m10", 16'h8001, 2'b10, 32'h8001_0000);
    run_one("m11", 16'h8001, 2'b11, 32'hFFFE_0004);

    // Back-pressure: 8 items, out_ready low for cycles 3..7.
    got = 0; held_v = 0; held = '0; saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int guard;
          in_valid = 1'b1; in_data = 16'(i + 1); in_mode = 2'b01;
          acc = 1'b0; guard = 0;
          while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            guard++;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60 && got < 8; c++) begin
          out_ready = !(c >= 3 && c < 8);
          @(negedge clk);
          if (!in_ready) saw_full = 1'b1;
          if (out_valid && out_ready) begin
            check("bp_order", out_data, 32'(got + 1));
            got++;
          end
          if (out_valid && !out_ready) begin
            if (held_v != 0) check("bp_stall_stable", out_data, held);
            held = out_data; held_v = 1;
          end else begin
            held_v = 0;
          end
          tick();
        end
      end
    join
    out_ready = 1'b1;
    check("bp_count", 32'(got), 32'd8);
    check("bp_in_ready_dropped", 32'(saw_full), 32'd1);
    tick();
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Full rate: 16 inputs back to back.
    got = 0; first = -1; last = -1;
    for (int i = 0; i < 24; i++) begin
      in_valid = (i < 16);
      in_data  = 16'h0100 + 16'(i);
      in_mode  = 2'b01;
      @(negedge clk);
      if (i < 16) check("fr_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        check("fr_data", out_data, 32'h0100 + 32'(got));
        if (got == 0) first = i;
        last = i;
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("fr_count", 32'(got), 32'd16);
    check("fr_consecutive", 32'(last - first), 32'd15);

    // Reset with two items held in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; in_mode = 2'b00;
    tick();
    in_data = 16'h5678;
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    ghosts = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) ghosts++;
    end
    tick();
    check("rst_no_ghost", 32'(ghosts), 32'd0);

    // Narrow builds, mode 11 on 8'h80, latency equal to DEPTH.
    s_in_valid = 1'b1; s_in_data = 8'h80; s_in_mode = 2'b11;
    tick();
    s_in_valid = 1'b0;
    cyc = 1; lat1 = 0; lat4 = 0; d1 = '0; d4 = '0;
    while ((lat1 == 0 || lat4 == 0) && cyc < 10) begin
      if (s1_out_valid && lat1 == 0) begin lat1 = cyc; d1 = s1_out_data; end
      if (s4_out_valid && lat4 == 0) begin lat4 = cyc; d4 = s4_out_data; end
      if (lat1 == 0 || lat4 == 0) begin
        tick();
        cyc++;
      end
    end
    check("sw_d1_latency", 32'(lat1), 32'd1);
    check("sw_d1_data", 32'(d1), 32'h0000_FE00);
    check("sw_d4_latency", 32'(lat4), 32'd4);
    check("sw_d4_data", 32'(d4), 32'h0000_FE00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate-extension unit for the CPU datapath. It takes an IN_W-bit immediate field and produces an OUT_W-bit operand in one of four modes: sign-extend, zero-extend, upper-load, or branch-offset (sign-extend then shift left 2). The result passes through a DEPTH-stage elastic pipeline with valid/ready handshakes on both sides. It replaces the fixed 16→32 combinational sign extender wherever the datapath is registered between decode and execute.

## Interface
- IN_W, 16, immediate input width; must satisfy 1 ≤ IN_W ≤ OUT_W-2
- OUT_W, 32, output operand width
- DEPTH, 2, number of pipeline register stages, 1..4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents a valid immediate
- in_ready  out  1  unit accepts the input this cycle
- in_data  in  IN_W  raw immediate field
- in_mode  in  2  00 sign, 01 zero, 10 upper, 11 branch offset
- out_valid  out  1  out_data holds a valid result
- out_ready  in  1  downstream accepts the result this cycle
- out_data  out  OUT_W  extended result

## Operation
- Extension is computed combinationally from in_data/in_mode and captured into stage 0 on input transfer (in_valid && in_ready).
- Mode 00: bits [OUT_W-1:IN_W] = in_data[IN_W-1]; low IN_W bits = in_data.
- Mode 01: upper bits 0; low IN_W bits = in_data.
- Mode 10: in_data placed in bits [OUT_W-1:OUT_W-IN_W]; remaining low bits 0.
- Mode 11: sign-extend as mode 00 to OUT_W, then shift left 2, bits shifted out of the MSB are discarded, bits [1:0] = 0.
- Each stage k holds v[k] and d[k]. Stage k loads when it is empty or its contents advance this cycle: adv[k] = v[k] && (k == DEPTH-1 ? out_ready : load[k+1]); load[k] = !v[k] || adv[k].
- in_ready = load[0]. Stage 0 sets v[0] = in_valid on load. Stage k>0 takes v[k-1]/d[k-1] on load.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Ready propagates combinationally back through the stages; there is no combinational path from in_valid/in_data to out_valid/out_data.
- A stage whose valid bit is cleared keeps its old data; out_data is only meaningful while out_valid = 1.
- Once out_valid is asserted, out_data stays constant until the output transfer (out_valid && out_ready) occurs.

## Timing
- Reset (rst_n low, asynchronous): every v[k] = 0 and every d[k] = 0, so out_valid = 0 and out_data = 0. in_ready is 1 during and after reset, because all stages are empty.
- Reset asserted mid-stream drops all in-flight results; no transfer occurs on the edge where rst_n is low.
- Latency: an input accepted at edge N appears with out_valid = 1 after edge N+DEPTH-1, i.e. DEPTH cycles of register delay.
- Throughput: one result per cycle while out_ready = 1.
- Full: all stages valid and out_ready = 0 gives in_ready = 0; nothing is overwritten.
- Simultaneous output transfer and input transfer when full: legal. The pipeline shifts by one and in_ready stays 1.
- Bubbles: with in_valid = 0, empty stages propagate and later stages still drain.
- Order is preserved; there is no reordering or duplication.

## Test plan
- Mode 00, in_data=16'hFFF0, then 16'h000F, out_ready=1 → out_data 32'hFFFFFFF0 then 32'h0000000F, each DEPTH cycles after its input.
- Modes 01/10/11 with in_data=16'h8001 → 32'h00008001, 32'h80010000, 32'hFFFE0004.
- Back-pressure: stream 8 sequential values, hold out_ready=0 for 5 cycles mid-stream → in_ready drops once DEPTH stages fill; all 8 values emerge in order with no loss or duplicates, and out_data is stable while stalled.
- Full-rate: out_ready=1 and in_valid=1 for 16 cycles → 16 outputs on consecutive cycles, with in_ready constantly 1.
- Reset mid-operation: with 2 items in flight, pulse rst_n low for a half cycle → out_valid=0 and out_data=0 immediately; in_ready=1; the old items never appear.
- Parameter sweep: IN_W=8, OUT_W=16, DEPTH=1 and 4, in_data=8'h80 in mode 11 → 16'hFE00, with latency equal to DEPTH.
